hazard_scoreboard: RTL and testbench
====================================

// Module: hazard_scoreboard
// PURPOSE
//  Parametrised hazard and forwarding controller for the in-order pipeline (F/D/E/.../W).
//  Tracks every in-flight destination register in a DEPTH-entry shift scoreboard.
//  Per decode-stage operand it generates a forwarding-source select.
//  Also generates load-use stalls and fetch/decode flushes for jumps and execute-resolved branches.
//  Generalises the fixed single-stage forwarding and jump stopper to any pipeline depth and load latency.
// PARAMETERS
//  REG_AW       5  register address width; address 0 = no write
//  DEPTH        2  stages after decode (entry 1 = execute ... entry DEPTH = write)
//  LOAD_STAGE   2  first entry index from which a load result may be forwarded (1..DEPTH)
//  JUMP_BUBBLES 1  flush_fd cycles after a decode-stage jump issues
//  BR_BUBBLES   2  flush_fd cycles for an execute redirect, including the redirect cycle
//  CNT_W        32 performance counter width (HAZ_PERF_EN only)
// PORTS
//  sysclk       in  1         clock, rising edge
//  cpu_resetn   in  1         asynchronous active-low reset
//  dec_valid    in  1         decode stage holds a valid instruction
//  dec_rs       in  REG_AW    source operand s (0 = unused)
//  dec_rt       in  REG_AW    source operand t (0 = unused)
//  dec_wreg     in  REG_AW    destination (0 = none)
//  dec_is_load  in  1         decode instruction is a load
//  dec_is_jump  in  1         decode instruction is an unconditional jump
//  exe_redirect in  1         branch taken in execute; kill younger instructions
//  stall        out 1         hold PC and F/D register; issue bubble into D/E
//  flush_fd     out 1         replace F/D contents with a bubble
//  fwd_s        out SELW      SELW=$clog2(DEPTH+1); 0 = reg file, k = entry k
//  fwd_t        out SELW      as fwd_s, for operand t
//  cyc_cnt      out CNT_W     cycles since reset (HAZ_PERF_EN)
//  stall_cnt    out CNT_W     stall cycles (HAZ_PERF_EN)
//  flush_cnt    out CNT_W     flush_fd cycles (HAZ_PERF_EN)
// BEHAVIOUR
//  - Entry state: {valid, wreg, ready_k}. ready_k = LOAD_STAGE for loads, 1 otherwise.
//  - Every edge: entries shift k -> k+1; entry DEPTH is dropped (reg file written at end of W).
//  - Entry 1 loads the decode instruction when issue = dec_valid & !stall & !exe_redirect & dec_wreg!=0.
//    Otherwise entry 1 loads a bubble (valid=0).
//  - Operand lookup (combinational from scoreboard + decode inputs), for src != 0:
//    - Find the smallest k with valid_k & wreg_k == src (the youngest producer wins).
//    - If k < ready_k: hazard. Else fwd = k.
//    - No match, or src == 0: fwd = 0.
//  - stall = dec_valid & !exe_redirect & (hazard_s | hazard_t).
//  - While stall is high, fwd outputs are don't-care and no counter reloads.
//  - Flush counter fcnt:
//    - exe_redirect: fcnt <= BR_BUBBLES-1, and flush_fd = 1 in that same cycle.
//    - Else a jump issuing (dec_valid & dec_is_jump & !stall): fcnt <= JUMP_BUBBLES.
//    - Else if fcnt != 0: fcnt decrements.
//    - flush_fd = exe_redirect | (fcnt != 0).
//  - Simultaneous events:
//    - Redirect beats jump and stall; the decode instruction is killed, never recorded.
//    - A jump arriving while fcnt != 0 reloads fcnt; it never extends additively.
//  - Reset (async, any cycle, mid-stall or mid-flush):
//    - All entries invalid, fcnt = 0, counters = 0.
//    - Hence stall = 0, flush_fd = 0, fwd_s = fwd_t = 0 immediately.
//  - No wrap protection on counters; they roll over modulo 2^CNT_W.
// CONFIGURATION
//  HAZ_PERF_EN defined:
//    cyc_cnt increments every cycle; stall_cnt when stall; flush_cnt when flush_fd.
//  HAZ_PERF_EN undefined:
//    Counters are not built; cyc_cnt, stall_cnt and flush_cnt are tied to 0.
// TESTING
//  T1: DEPTH=2; issue add r9<-. Next cycle decode rs=9 -> fwd_s=1, stall=0. Following cycle -> fwd_s=2. Then 0.
//  T2: load r3, then dec rt=3 next cycle -> stall=1 for exactly 1 cycle. Then fwd_t=2, stall=0.
//  T3: two writers to r4 back to back, then rs=4 -> fwd_s=1 (youngest); rs=0 -> fwd_s=0 always.
//  T4: jump issues -> flush_fd=1 for JUMP_BUBBLES=1 cycle. exe_redirect with a jump in decode -> flush_fd high 2 cycles, no jump reload, entry 1 bubble.
//  T5: assert cpu_resetn=0 mid-stall and mid-flush -> stall, flush_fd, fwd_* read 0 before the next edge. Scoreboard is empty after release.
//  T6: HAZ_PERF_EN on, 10 cycles with 2 stalls and 3 flushes -> cyc_cnt=10, stall_cnt=2, flush_cnt=3. Off -> all read 0.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: hazard and forwarding controller for an in-order pipeline.
// A DEPTH-entry shift scoreboard records the destination register of every
// instruction downstream of decode. From it the block derives forwarding
// selects for both decode operands, load-use stalls, and fetch/decode flushes
// for decode-stage jumps and execute-resolved branches.
// Optional feature macro: HAZ_PERF_EN builds the cycle/stall/flush counters;
// without it the counter outputs are tied to zero.
module hazard_scoreboard #(
  parameter int REG_AW       = 5,
  parameter int DEPTH        = 2,
  parameter int LOAD_STAGE   = 2,
  parameter int JUMP_BUBBLES = 1,
  parameter int BR_BUBBLES   = 2,
  parameter int CNT_W        = 32,
  localparam int SELW        = $clog2(DEPTH + 1)
) (
  input  logic              sysclk,
  input  logic              cpu_resetn,
  input  logic              dec_valid,
  input  logic [REG_AW-1:0] dec_rs,
  input  logic [REG_AW-1:0] dec_rt,
  input  logic [REG_AW-1:0] dec_wreg,
  input  logic              dec_is_load,
  input  logic              dec_is_jump,
  input  logic              exe_redirect,
  output logic              stall,
  output logic              flush_fd,
  output logic [SELW-1:0]   fwd_s,
  output logic [SELW-1:0]   fwd_t,
  output logic [CNT_W-1:0]  cyc_cnt,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  // Flush counter must hold the larger of the two reload values.
  localparam int FMAX = (JUMP_BUBBLES > BR_BUBBLES - 1) ? JUMP_BUBBLES : BR_BUBBLES - 1;
  localparam int FCW  = (FMAX < 1) ? 1 : $clog2(FMAX + 1);

  // Scoreboard entries: index 1 = execute ... index DEPTH = write-back.
  logic              valid_q [1:DEPTH];
  logic [REG_AW-1:0] wreg_q  [1:DEPTH];
  logic [SELW-1:0]   rdy_q   [1:DEPTH];

  logic [FCW-1:0]    fcnt_q, fcnt_d;
  logic [SELW-1:0]   match_s, match_t;
  logic [SELW-1:0]   rdy_s, rdy_t;
  logic              hazard_s, hazard_t;
  logic              issue, jump_issue;

  // Youngest-producer lookup per operand; the descending loop lets the
  // smallest matching index overwrite any older match.
  always_comb begin
    match_s = '0;
    match_t = '0;
    rdy_s   = '0;
    rdy_t   = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (dec_rs != '0 && valid_q[k] && wreg_q[k] == dec_rs) begin
        match_s = SELW'(k);
        rdy_s   = rdy_q[k];
      end
      if (dec_rt != '0 && valid_q[k] && wreg_q[k] == dec_rt) begin
        match_t = SELW'(k);
        rdy_t   = rdy_q[k];
      end
    end
  end

  // A producer whose result is not yet available at its stage is a hazard.
  assign hazard_s   = (match_s != '0) && (match_s < rdy_s);
  assign hazard_t   = (match_t != '0) && (match_t < rdy_t);
  assign fwd_s      = hazard_s ? '0 : match_s;
  assign fwd_t      = hazard_t ? '0 : match_t;

  assign stall      = dec_valid & ~exe_redirect & (hazard_s | hazard_t);
  assign issue      = dec_valid & ~stall & ~exe_redirect & (dec_wreg != '0);
  assign jump_issue = dec_valid & dec_is_jump & ~stall;
  assign flush_fd   = exe_redirect | (fcnt_q != '0);

  // Flush counter next state: redirect outranks jump; a jump reloads, never adds.
  always_comb begin
    fcnt_d = fcnt_q;
    if (exe_redirect) begin
      fcnt_d = FCW'(BR_BUBBLES - 1);
    end else if (jump_issue) begin
      fcnt_d = FCW'(JUMP_BUBBLES);
    end else if (fcnt_q != '0) begin
      fcnt_d = fcnt_q - 1'b1;
    end
  end

  // Scoreboard shift: entry 1 takes the issuing instruction (or a bubble),
  // every other entry takes its younger neighbour; entry DEPTH falls off.
  always_ff @(posedge sysclk or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      for (int k = 1; k <= DEPTH; k++) begin
        valid_q[k] <= 1'b0;
        wreg_q[k]  <= '0;
        rdy_q[k]   <= '0;
      end
    end else begin
      valid_q[1] <= issue;
      wreg_q[1]  <= issue ? dec_wreg : '0;
      rdy_q[1]   <= dec_is_load ? SELW'(LOAD_STAGE) : SELW'(1);
      for (int k = 2; k <= DEPTH; k++) begin
        valid_q[k] <= valid_q[k-1];
        wreg_q[k]  <= wreg_q[k-1];
        rdy_q[k]   <= rdy_q[k-1];
      end
    end
  end

  // Flush bubble counter register.
  always_ff @(posedge sysclk or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      fcnt_q <= '0;
    end else begin
      fcnt_q <= fcnt_d;
    end
  end

`ifdef HAZ_PERF_EN
  logic [CNT_W-1:0] cyc_q, stall_q, flush_q;

  // Free-running performance counters; they wrap silently.
  always_ff @(posedge sysclk or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      cyc_q   <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      cyc_q <= cyc_q + 1'b1;
      if (stall)    stall_q <= stall_q + 1'b1;
      if (flush_fd) flush_q <= flush_q + 1'b1;
    end
  end

  assign cyc_cnt   = cyc_q;
  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign cyc_cnt   = '0;
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed testbench for hazard_scoreboard with default parameters
// (DEPTH=2, LOAD_STAGE=2, JUMP_BUBBLES=1, BR_BUBBLES=2).
module tb_hazard_scoreboard;

  logic        sysclk = 1'b0;
  logic        cpu_resetn;
  logic        dec_valid;
  logic [4:0]  dec_rs, dec_rt, dec_wreg;
  logic        dec_is_load, dec_is_jump, exe_redirect;
  logic        stall, flush_fd;
  logic [1:0]  fwd_s, fwd_t;
  logic [31:0] cyc_cnt, stall_cnt, flush_cnt;

  int errors = 0;
  int checks = 0;

  hazard_scoreboard dut (
    .sysclk      (sysclk),
    .cpu_resetn  (cpu_resetn),
    .dec_valid   (dec_valid),
    .dec_rs      (dec_rs),
    .dec_rt      (dec_rt),
    .dec_wreg    (dec_wreg),
    .dec_is_load (dec_is_load),
    .dec_is_jump (dec_is_jump),
    .exe_redirect(exe_redirect),
    .stall       (stall),
    .flush_fd    (flush_fd),
    .fwd_s       (fwd_s),
    .fwd_t       (fwd_t),
    .cyc_cnt     (cyc_cnt),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
  );

  always #5 sysclk = ~sysclk;

  // Apply one decode-stage vector.
  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] wr, input logic ld, input logic jmp,
                       input logic rd);
    dec_valid    = v;
    dec_rs       = rs;
    dec_rt       = rt;
    dec_wreg     = wr;
    dec_is_load  = ld;
    dec_is_jump  = jmp;
    exe_redirect = rd;
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick;
    @(posedge sysclk);
    #1;
  endtask

  task automatic test_reset;
    drive(1'b1, 5'd9, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %0b want 0", stall); end
    checks++; if (flush_fd !== 1'b0) begin errors++; $display("FAIL reset_flush: got %0b want 0", flush_fd); end
    checks++; if (fwd_s !== 2'd0) begin errors++; $display("FAIL reset_fwd_s: got %0d want 0", fwd_s); end
    checks++; if (fwd_t !== 2'd0) begin errors++; $display("FAIL reset_fwd_t: got %0d want 0", fwd_t); end
    tick;
    cpu_resetn = 1'b1;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick; tick;
    $display("test_reset done");
  endtask

  task automatic test_forward;
    drive(1'b1, 5'd0, 5'd0, 5'd9, 1'b0, 1'b0, 1'b0);   // add r9
    #1; tick;
    drive(1'b1, 5'd9, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    checks++; if (fwd_s !== 2'd1) begin errors++; $display("FAIL fwd_e1: got %0d want 1", fwd_s); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL fwd_e1_stall: got %0b want 0", stall); end
    tick;
    #1;
    checks++; if (fwd_s !== 2'd2) begin errors++; $display("FAIL fwd_e2: got %0d want 2", fwd_s); end
    tick;
    #1;
    checks++; if (fwd_s !== 2'd0) begin errors++; $display("FAIL fwd_retired: got %0d want 0", fwd_s); end
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick;
    $display("test_forward done");
  endtask

  task automatic test_load_use;
    drive(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0);   // load r3
    #1; tick;
    drive(1'b1, 5'd0, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall: got %0b want 1", stall); end
    tick;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_release: got %0b want 0", stall); end
    checks++; if (fwd_t !== 2'd2) begin errors++; $display("FAIL lu_fwd_t: got %0d want 2", fwd_t); end
    checks++; if (fwd_s !== 2'd0) begin errors++; $display("FAIL lu_fwd_s: got %0d want 0", fwd_s); end
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick; tick;
    $display("test_load_use done");
  endtask

  task automatic test_back_to_back;
    drive(1'b1, 5'd0, 5'd0, 5'd4, 1'b0, 1'b0, 1'b0);
    #1;
    checks++; if (fwd_s !== 2'd0) begin errors++; $display("FAIL b2b_rs0: got %0d want 0", fwd_s); end
    tick;
    drive(1'b1, 5'd0, 5'd0, 5'd4, 1'b0, 1'b0, 1'b0);
    #1; tick;
    drive(1'b1, 5'd4, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    checks++; if (fwd_s !== 2'd1) begin errors++; $display("FAIL b2b_youngest: got %0d want 1", fwd_s); end
    drive(1'b1, 5'd0, 5'd4, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    checks++; if (fwd_s !== 2'd0) begin errors++; $display("FAIL b2b_rs_zero: got %0d want 0", fwd_s); end
    checks++; if (fwd_t !== 2'd1) begin errors++; $display("FAIL b2b_fwd_t: got %0d want 1", fwd_t); end
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick; tick;
    $display("test_back_to_back done");
  endtask

  task automatic test_flush;
    // Single jump: one bubble on the following cycle.
    drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    #1;
    checks++; if (flush_fd !== 1'b0) begin errors++; $display("FAIL jmp_c0: got %0b want 0", flush_fd); end
    tick;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    checks++; if (flush_fd !== 1'b1) begin errors++; $display("FAIL jmp_c1: got %0b want 1", flush_fd); end
    tick;
    #1;
    checks++; if (flush_fd !== 1'b0) begin errors++; $display("FAIL jmp_c2: got %0b want 0", flush_fd); end
    // Jump during an active flush reloads rather than extends.
    drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    #1; tick;
    #1;
    checks++; if (flush_fd !== 1'b1) begin errors++; $display("FAIL jj_c1: got %0b want 1", flush_fd); end
    tick;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    checks++; if (flush_fd !== 1'b1) begin errors++; $display("FAIL jj_c2: got %0b want 1", flush_fd); end
    tick;
    #1;
    checks++; if (flush_fd !== 1'b0) begin errors++; $display("FAIL jj_c3: got %0b want 0", flush_fd); end
    // Redirect with a jump writing r7 in decode: killed, two flush cycles.
    drive(1'b1, 5'd0, 5'd0, 5'd7, 1'b0, 1'b1, 1'b1);
    #1;
    checks++; if (flush_fd !== 1'b1) begin errors++; $display("FAIL br_c0: got %0b want 1", flush_fd); end
    tick;
    drive(1'b1, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    checks++; if (flush_fd !== 1'b1) begin errors++; $display("FAIL br_c1: got %0b want 1", flush_fd); end
    checks++; if (fwd_s !== 2'd0) begin errors++; $display("FAIL br_killed: got %0d want 0", fwd_s); end
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick;
    #1;
    checks++; if (flush_fd !== 1'b0) begin errors++; $display("FAIL br_c2: got %0b want 0", flush_fd); end
    // Redirect suppresses a load-use stall.
    drive(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0);
    #1; tick;
    drive(1'b1, 5'd0, 5'd3, 5'd0, 1'b0, 1'b0, 1'b1);
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL br_over_stall: got %0b want 0", stall); end
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick; tick; tick;
    $display("test_flush done");
  endtask

  task automatic test_async_reset;
    // Mid-flush.
    drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    #1; tick;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    cpu_resetn = 1'b0;
    #1;
    checks++; if (flush_fd !== 1'b0) begin errors++; $display("FAIL ar_flush: got %0b want 0", flush_fd); end
    tick;
    cpu_resetn = 1'b1;
    // Mid-stall.
    drive(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0);
    #1; tick;
    drive(1'b1, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL ar_pre_stall: got %0b want 1", stall); end
    cpu_resetn = 1'b0;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL ar_stall: got %0b want 0", stall); end
    tick;
    cpu_resetn = 1'b1;
    // Mid-forward.
    drive(1'b1, 5'd0, 5'd0, 5'd6, 1'b0, 1'b0, 1'b0);
    #1; tick;
    drive(1'b1, 5'd5, 5'd6, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    checks++; if (fwd_t !== 2'd1) begin errors++; $display("FAIL ar_pre_fwd: got %0d want 1", fwd_t); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL ar_empty_sb: got %0b want 0", stall); end
    cpu_resetn = 1'b0;
    #1;
    checks++; if (fwd_t !== 2'd0) begin errors++; $display("FAIL ar_fwd_t: got %0d want 0", fwd_t); end
    tick;
    cpu_resetn = 1'b1;
    #1;
    checks++; if (fwd_t !== 2'd0) begin errors++; $display("FAIL ar_after: got %0d want 0", fwd_t); end
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick;
    $display("test_async_reset done");
  endtask

  task automatic test_perf;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    cpu_resetn = 1'b0;
    tick;
    cpu_resetn = 1'b1;
    drive(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0); tick;   // c1 load r3
    drive(1'b1, 5'd0, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0); tick;   // c2 stall
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0); tick;   // c3
    drive(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0); tick;   // c4 load r3
    drive(1'b1, 5'd0, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0); tick;   // c5 stall
    drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0); tick;   // c6 jump
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0); tick;   // c7 flush
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1); tick;   // c8 redirect flush
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0); tick;   // c9 flush
    tick;                                                     // c10
    #1;
`ifdef HAZ_PERF_EN
    checks++; if (cyc_cnt !== 32'd10) begin errors++; $display("FAIL perf_cyc: got %0d want 10", cyc_cnt); end
    checks++; if (stall_cnt !== 32'd2) begin errors++; $display("FAIL perf_stall: got %0d want 2", stall_cnt); end
    checks++; if (flush_cnt !== 32'd3) begin errors++; $display("FAIL perf_flush: got %0d want 3", flush_cnt); end
`else
    checks++; if (cyc_cnt !== 32'd0) begin errors++; $display("FAIL perf_cyc_off: got %0d want 0", cyc_cnt); end
    checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL perf_stall_off: got %0d want 0", stall_cnt); end
    checks++; if (flush_cnt !== 32'd0) begin errors++; $display("FAIL perf_flush_off: got %0d want 0", flush_cnt); end
`endif
    $display("test_perf done");
  endtask

  initial begin
    cpu_resetn = 1'b0;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick; tick;
    test_reset;
    test_forward;
    test_load_use;
    test_back_to_back;
    test_flush;
    test_async_reset;
    test_perf;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
